// File: rtl/led_pkg.sv
// Shared definitions for the LED pattern engine: mode encodings, shift direction, PWM width.
// The optional brightness gate in led_pattern_gen is enabled by defining LED_PWM_EN.
package led_pkg;

    typedef logic [2:0] mode_t;

    localparam mode_t MODE_WALK_R = 3'd0;
    localparam mode_t MODE_WALK_L = 3'd1;
    localparam mode_t MODE_BOUNCE = 3'd2;
    localparam mode_t MODE_COUNT  = 3'd3;
    localparam mode_t MODE_BLINK  = 3'd4;

    typedef enum logic {
        DIR_RIGHT = 1'b0,
        DIR_LEFT  = 1'b1
    } dir_t;

    localparam int PWM_W = 8;

endpackage

// File: rtl/led_tick_gen.sv
// Step prescaler: counts 0..DIV-1 while enabled and pulses tick for the terminal count cycle.
// Disabling freezes the count where it is and masks tick.
module led_tick_gen
    import led_pkg::*;
#(
    parameter int DIV = 8388608
) (
    input  logic clk,
    input  logic nreset,
    input  logic en,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    assign tick = en && (count_reg == LAST);

    always_comb begin
        count_next = count_reg;
        if (en) begin
            count_next = tick ? '0 : count_reg + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern engine: a prescaled step tick advances a pattern register in one of five modes.
// Define LED_PWM_EN to add an 8-bit duty-cycle brightness gate (and the duty port).
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int LED_W = 8,
    parameter int DIV   = 8388608
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             en,
    input  logic [2:0]       mode,
`ifdef LED_PWM_EN
    input  logic [PWM_W-1:0] duty,
`endif
    output logic [LED_W-1:0] led,
    output logic             tick
);

    localparam logic [LED_W-1:0] MSB_ONLY = {1'b1, {(LED_W-1){1'b0}}};
    localparam logic [LED_W-1:0] LSB_ONLY = {{(LED_W-1){1'b0}}, 1'b1};

    logic [LED_W-1:0] pattern_reg, pattern_next;
    mode_t            mode_q_reg, mode_q_next;
    dir_t             dir_reg, dir_next;

    function automatic logic [LED_W-1:0] seed(input mode_t m);
        case (m)
            MODE_BOUNCE: seed = MSB_ONLY;
            MODE_BLINK:  seed = '1;
            default:     seed = '0;
        endcase
    endfunction

    led_tick_gen #(.DIV(DIV)) u_tick_gen (
        .clk    (clk),
        .nreset (nreset),
        .en     (en),
        .tick   (tick)
    );

    always_comb begin
        pattern_next = pattern_reg;
        mode_q_next  = mode_q_reg;
        dir_next     = dir_reg;
        if (tick) begin
            if (mode != mode_q_reg) begin
                // A new mode restarts from its seed on the step boundary only.
                mode_q_next  = mode;
                pattern_next = seed(mode);
                dir_next     = DIR_RIGHT;
            end else begin
                case (mode_q_reg)
                    MODE_WALK_R: pattern_next = (pattern_reg == '0) ? MSB_ONLY : pattern_reg >> 1;
                    MODE_WALK_L: pattern_next = (pattern_reg == '0) ? LSB_ONLY : pattern_reg << 1;
                    MODE_BOUNCE: begin
                        // Turning at an end moves straight off it, so end LEDs show for one step.
                        if (pattern_reg == '0) begin
                            pattern_next = MSB_ONLY;
                        end else if (dir_reg == DIR_RIGHT) begin
                            if (pattern_reg[0]) begin
                                pattern_next = pattern_reg << 1;
                                dir_next     = DIR_LEFT;
                            end else begin
                                pattern_next = pattern_reg >> 1;
                            end
                        end else begin
                            if (pattern_reg[LED_W-1]) begin
                                pattern_next = pattern_reg >> 1;
                                dir_next     = DIR_RIGHT;
                            end else begin
                                pattern_next = pattern_reg << 1;
                            end
                        end
                    end
                    MODE_COUNT:  pattern_next = pattern_reg + LSB_ONLY;
                    MODE_BLINK:  pattern_next = ~pattern_reg;
                    default:     pattern_next = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            pattern_reg <= '0;
            mode_q_reg  <= MODE_WALK_R;
            dir_reg     <= DIR_RIGHT;
        end else begin
            pattern_reg <= pattern_next;
            mode_q_reg  <= mode_q_next;
            dir_reg     <= dir_next;
        end
    end

`ifdef LED_PWM_EN
    logic [PWM_W-1:0] pwm_cnt_reg;
    logic [LED_W-1:0] led_reg;
    logic [LED_W-1:0] gated;
    logic             pwm_on;

    assign pwm_on = (pwm_cnt_reg < duty);

    for (genvar gi = 0; gi < LED_W; gi++) begin : g_gate
        assign gated[gi] = pattern_reg[gi] & pwm_on;
    end

    // The PWM counter free-runs regardless of en so frozen patterns keep their brightness.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            pwm_cnt_reg <= '0;
            led_reg     <= '0;
        end else begin
            pwm_cnt_reg <= pwm_cnt_reg + PWM_W'(1);
            led_reg     <= gated;
        end
    end

    assign led = led_reg;
`else
    assign led = pattern_reg;
`endif

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen (LED_W=8, DIV=4): step-vector table plus timing corner cases.
// Define LED_PWM_EN to also exercise the brightness gate.
module tb_led_pattern_gen;

    logic       clk;
    logic       nreset;
    logic       en;
    logic [2:0] mode;
    logic [7:0] led;
    logic       tick;
`ifdef LED_PWM_EN
    logic [7:0] duty;
`endif

    int tests = 0;
    int fails = 0;
    int tick_cnt = 0;

    typedef struct {
        logic [2:0] mode;
        logic [7:0] exp_led;
    } vec_t;

    vec_t vecs[$];

    led_pattern_gen #(.LED_W(8), .DIV(4)) dut (
        .clk    (clk),
        .nreset (nreset),
        .en     (en),
        .mode   (mode),
`ifdef LED_PWM_EN
        .duty   (duty),
`endif
        .led    (led),
        .tick   (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (tick) tick_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("[TB] ok   %s: %0h", name, act);
        end
    endtask

    // Wait for a tick (bounded), then one more negedge so the stepped pattern is visible.
    task automatic do_step();
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (tick) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("[TB] FAIL tick_timeout: got no tick, expected one within 20 clks");
        end
        @(negedge clk);
    endtask

    task automatic add(input logic [2:0] m, input logic [7:0] e);
        vec_t v;
        v.mode    = m;
        v.exp_led = e;
        vecs.push_back(v);
    endtask

    initial begin
        int n;
        int t0;
        int hits;
        logic [7:0] held;
        logic frozen_ok;

        // WALK_R from reset, including the blank step and restart
        add(0, 8'h80); add(0, 8'h40); add(0, 8'h20); add(0, 8'h10); add(0, 8'h08);
        add(0, 8'h04); add(0, 8'h02); add(0, 8'h01); add(0, 8'h00); add(0, 8'h80);
        // BOUNCE: ends lit once, period 14
        add(2, 8'h80); add(2, 8'h40); add(2, 8'h20); add(2, 8'h10); add(2, 8'h08);
        add(2, 8'h04); add(2, 8'h02); add(2, 8'h01); add(2, 8'h02); add(2, 8'h04);
        add(2, 8'h08); add(2, 8'h10); add(2, 8'h20); add(2, 8'h40); add(2, 8'h80);
        add(2, 8'h40);
        // BLINK, reserved, WALK_L, COUNT, back to WALK_R
        add(4, 8'hFF); add(4, 8'h00); add(4, 8'hFF);
        add(6, 8'h00); add(6, 8'h00);
        add(1, 8'h00); add(1, 8'h01); add(1, 8'h02); add(1, 8'h04);
        add(3, 8'h00); add(3, 8'h01); add(3, 8'h02); add(3, 8'h03);
        add(0, 8'h00); add(0, 8'h80);

        nreset = 1'b0;
        en     = 1'b0;
        mode   = 3'd0;
`ifdef LED_PWM_EN
        duty   = 8'd0;
`endif
        repeat (3) @(negedge clk);
        check("reset_led", {24'd0, led}, 32'h00);
        check("reset_tick", {31'd0, tick}, 32'd0);

        nreset = 1'b1;
        en     = 1'b1;

        foreach (vecs[i]) begin
            mode = vecs[i].mode;
            do_step();
            check($sformatf("vec%0d_mode%0d", i, vecs[i].mode), {24'd0, led}, {24'd0, vecs[i].exp_led});
        end

        // Tick period: distance between consecutive ticks
        do_step();
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            n++;
            if (tick) break;
        end
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            n = (k == 0) ? 1 : n + 1;
            if (tick) break;
        end
        check("tick_period", n, 4);

        // Mode change between ticks has no effect until the step
        do_step();
        held = led;
        mode = 3'd4;
        @(negedge clk);
        check("midstep_mode_hold1", {24'd0, led}, {24'd0, held});
        @(negedge clk);
        check("midstep_mode_hold2", {24'd0, led}, {24'd0, held});
        do_step();
        check("midstep_blink1", {24'd0, led}, 32'hFF);
        do_step();
        check("midstep_blink2", {24'd0, led}, 32'h00);

        // Freeze with en=0 at count 1, then resume with the same remaining prescale
        do_step();
        @(negedge clk);
        en = 1'b0;
        held = led;
        frozen_ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (tick !== 1'b0 || led !== held) frozen_ok = 1'b0;
        end
        check("freeze_hold", {31'd0, frozen_ok}, 32'd1);
        en = 1'b1;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            n++;
            if (tick) break;
        end
        check("freeze_resume_clks", n, 2);
        @(negedge clk);

        // COUNT through the full 8-bit range and wrap
        mode = 3'd3;
        t0 = tick_cnt;
        do_step();
        check("count_0", {24'd0, led}, 32'h00);
        for (int v = 1; v < 256; v++) begin
            do_step();
            check($sformatf("count_%0d", v), {24'd0, led}, v);
        end
        check("count_ticks", tick_cnt - t0, 256);
        do_step();
        check("count_wrap", {24'd0, led}, 32'h00);

        // Asynchronous reset between edges
        @(negedge clk);
        #2;
        nreset = 1'b0;
        #1;
        check("async_reset_led", {24'd0, led}, 32'h00);
        check("async_reset_tick", {31'd0, tick}, 32'd0);
        mode = 3'd0;
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        do_step();
        check("post_reset_first_step", {24'd0, led}, 32'h80);

`ifdef LED_PWM_EN
        // Hold an all-ones pattern (en=0) and measure the gated duty
        mode = 3'd4;
        do_step();
        en = 1'b0;
        duty = 8'd64;
        repeat (4) @(negedge clk);
        hits = 0;
        repeat (256) begin
            @(negedge clk);
            if (led == 8'hFF) hits++;
        end
        check("pwm_duty64", hits, 64);
        duty = 8'd0;
        repeat (4) @(negedge clk);
        hits = 0;
        repeat (256) begin
            @(negedge clk);
            if (led != 8'h00) hits++;
        end
        check("pwm_duty0", hits, 0);
`else
        hits = 0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
